// File: rtl/soc_top_pmux_pkg.sv
// Shared constants for the pmux SoC: opcodes, timer register indices and control-register fields.
package soc_top_pmux_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_TWR = 4'h1,
    OP_PWR = 4'h2,
    OP_JMP = 4'h3
  } opcode_e;

  localparam logic [1:0] REG_SCR = 2'd0;
  localparam logic [1:0] REG_CMP = 2'd1;
  localparam logic [1:0] REG_CTL = 2'd2;
  localparam logic [1:0] REG_PER = 2'd3;

  localparam int         CTL_EN    = 7;
  // Reserved CTL bits 6:4 are forced to zero on write so they always read back 0.
  localparam logic [7:0] CTL_WMASK = 8'h8F;

endpackage

// File: rtl/soc_cpu.sv
// Tiny CPU: program counter, instruction decode, jump squash and the port data latch.
module soc_cpu
  import soc_top_pmux_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ins,
  output logic [6:0]  pc,
  output logic [3:0]  pdat,
  output logic        twr_en,
  output logic [1:0]  twr_idx,
  output logic [7:0]  twr_data
);

  logic    squash;
  opcode_e op;

  assign op = opcode_e'(ins[15:12]);

  always_comb begin
    twr_en   = !squash && (op == OP_TWR);
    twr_idx  = ins[9:8];
    twr_data = ins[7:0];
  end

  // The word fetched during a taken jump belongs to the old stream and is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      pdat   <= '0;
      squash <= 1'b0;
    end else begin
      pc     <= pc + 7'd1;
      squash <= 1'b0;
      if (!squash) begin
        case (op)
          OP_PWR: pdat <= ins[3:0];
          OP_JMP: begin
            pc     <= ins[6:0];
            squash <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/soc_timer.sv
// 8-bit timer with scratch/compare/control/period registers, registered overflow and combinational compare event.
module soc_timer
  import soc_top_pmux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_idx,
  input  logic [7:0] wr_data,
  output logic [7:0] ctl,
  output logic       ov,
  output logic       pwm
);

  logic [7:0] tmr_reg [4];
  logic [7:0] cnt;

  assign ctl = tmr_reg[REG_CTL];
  assign pwm = (cnt == tmr_reg[REG_CMP]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) tmr_reg[i] <= '0;
    end else if (wr_en) begin
      tmr_reg[wr_idx] <= (wr_idx == REG_CTL) ? (wr_data & CTL_WMASK) : wr_data;
    end
  end

  // Wrap at PER takes priority over enable, so a disabled counter sitting on PER still clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ov  <= 1'b0;
    end else begin
      ov <= (cnt == tmr_reg[REG_PER]);
      if (cnt == tmr_reg[REG_PER])
        cnt <= '0;
      else if (tmr_reg[REG_CTL][CTL_EN])
        cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/soc_top_pmux.sv
// SoC top: CPU fetching from external memory, timer, and the pin mux driving porta.
module soc_top_pmux
  import soc_top_pmux_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ins_out,
  output logic [6:0]  pc,
  output logic [3:0]  porta
);

  logic [3:0] pdat;
  logic       twr_en;
  logic [1:0] twr_idx;
  logic [7:0] twr_data;
  logic [7:0] ctl;
  logic       ov;
  logic       pwm;

  soc_cpu cpu (
    .clk      (clk),
    .rst      (rst),
    .ins      (ins_out),
    .pc       (pc),
    .pdat     (pdat),
    .twr_en   (twr_en),
    .twr_idx  (twr_idx),
    .twr_data (twr_data)
  );

  soc_timer timer (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (twr_en),
    .wr_idx  (twr_idx),
    .wr_data (twr_data),
    .ctl     (ctl),
    .ov      (ov),
    .pwm     (pwm)
  );

  // A pin claimed by either event select shows the OR of its events; otherwise it shows the port latch.
  always_comb begin
    porta = '0;
    for (int i = 0; i < 4; i++) begin
      if (ctl[1:0] == 2'(i) || ctl[3:2] == 2'(i))
        porta[i] = ((ctl[1:0] == 2'(i)) && ov) || ((ctl[3:2] == 2'(i)) && pwm);
      else
        porta[i] = pdat[i];
    end
  end

endmodule

// File: tb/tb_soc_top_pmux.sv
// Self-checking bench for soc_top_pmux: external instruction memory plus a cycle-level reference model.
module tb_soc_top_pmux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ins_out;
  logic [6:0]  pc;
  logic [3:0]  porta;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [128];

  soc_top_pmux dut (
    .clk     (clk),
    .rst     (rst),
    .ins_out (ins_out),
    .pc      (pc),
    .porta   (porta)
  );

  always #5 clk = ~clk;

  // External synchronous memory: ins_out is mem[pc] registered one cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) ins_out <= 16'h0000;
    else     ins_out <= mem[pc];
  end

  // Reference model state
  logic [6:0]  m_pc;
  logic [15:0] m_ins;
  logic        m_sq;
  logic [7:0]  m_tmr [4];
  logic [7:0]  m_cnt;
  logic        m_ov;
  logic [3:0]  m_pdat;

  function automatic logic [15:0] w_twr(input int idx, input int d);
    return 16'h1000 | 16'((idx & 3) << 8) | 16'(d & 8'hFF);
  endfunction
  function automatic logic [15:0] w_pwr(input int d);
    return 16'h2000 | 16'(d & 4'hF);
  endfunction
  function automatic logic [15:0] w_jmp(input int t);
    return 16'h3000 | 16'(t & 7'h7F);
  endfunction

  function automatic logic [3:0] model_porta();
    logic [3:0] p;
    logic       pwm;
    pwm = (m_cnt == m_tmr[1]);
    for (int i = 0; i < 4; i++) begin
      logic on_ov, on_pwm;
      on_ov  = (m_tmr[2][1:0] == 2'(i));
      on_pwm = (m_tmr[2][3:2] == 2'(i));
      p[i] = (on_ov || on_pwm) ? ((on_ov && m_ov) || (on_pwm && pwm)) : m_pdat[i];
    end
    return p;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_ins = 0; m_sq = 0; m_cnt = 0; m_ov = 0; m_pdat = 0;
    for (int i = 0; i < 4; i++) m_tmr[i] = 0;
  endtask

  // One rising edge of the whole system, from the instruction set rules.
  task automatic model_step();
    logic [6:0]  n_pc;
    logic        n_sq;
    logic [7:0]  n_cnt;
    logic        n_ov;
    n_pc = 7'(m_pc + 1);
    n_sq = 0;
    n_ov = (m_cnt == m_tmr[3]);
    if (m_cnt == m_tmr[3])  n_cnt = 0;
    else if (m_tmr[2][7])   n_cnt = m_cnt + 1;
    else                    n_cnt = m_cnt;
    if (!m_sq) begin
      case (m_ins[15:12])
        4'h1: m_tmr[m_ins[9:8]] = (m_ins[9:8] == 2) ? (m_ins[7:0] & 8'h8F) : m_ins[7:0];
        4'h2: m_pdat = m_ins[3:0];
        4'h3: begin n_pc = m_ins[6:0]; n_sq = 1; end
        default: ;
      endcase
    end
    m_ins = mem[m_pc];
    m_pc = n_pc; m_sq = n_sq; m_cnt = n_cnt; m_ov = n_ov;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_nops();
    for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    load_nops();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 7'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", pc); end
    checks++;
    if (porta !== 4'b0001) begin errors++; $display("FAIL reset_porta got %b want 0001", porta); end
  endtask

  task automatic test_nop_count();
    load_nops();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (pc !== 7'(i + 1)) begin errors++; $display("FAIL nop_pc got %0d want %0d", pc, i + 1); end
      checks++;
      if (porta !== 4'b0001) begin errors++; $display("FAIL nop_porta got %b want 0001", porta); end
    end
  endtask

  task automatic run_program(input string name, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      checks++;
      if (pc !== m_pc) begin errors++; $display("FAIL %s_pc cyc %0d got %0d want %0d", name, i, pc, m_pc); end
      checks++;
      if (porta !== model_porta()) begin
        errors++; $display("FAIL %s_porta cyc %0d got %b want %b", name, i, porta, model_porta());
      end
    end
  endtask

  task automatic test_timer_pwm();
    int ov_edges;
    logic prev;
    load_nops();
    mem[0] = w_twr(3, 5);
    mem[1] = w_twr(1, 2);
    mem[2] = w_twr(2, 8'h84);
    do_reset();
    run_program("timer", 12);
    // Spacing between successive pin0 rising edges must be the 6-cycle period.
    ov_edges = 0; prev = porta[0];
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (porta[0] && !prev) ov_edges++;
      prev = porta[0];
    end
    checks++;
    if (ov_edges != 4) begin errors++; $display("FAIL timer_ov_period got %0d pulses want 4", ov_edges); end
  endtask

  task automatic test_shared_pin();
    load_nops();
    mem[0] = w_twr(3, 5);
    mem[1] = w_twr(1, 2);
    mem[2] = w_twr(2, 8'h8F);
    mem[3] = w_pwr(5);
    do_reset();
    run_program("shared", 10);
    for (int i = 0; i < 12; i++) begin
      cycle();
      checks++;
      if (porta[2:0] !== 3'b101) begin errors++; $display("FAIL shared_pdat got %b want 101", porta[2:0]); end
    end
  endtask

  task automatic test_disable();
    load_nops();
    mem[0] = w_twr(3, 7);
    mem[1] = w_twr(2, 8'h80);
    mem[6] = w_twr(2, 8'h00);
    mem[20] = w_twr(2, 8'h80);
    do_reset();
    run_program("disable", 30);
  endtask

  task automatic test_jmp();
    logic [6:0] want [4];
    load_nops();
    mem[4] = w_jmp(16'h10);
    mem[5] = w_twr(2, 8'h8F);
    do_reset();
    want[0] = 7'd4; want[1] = 7'd5; want[2] = 7'h10; want[3] = 7'h11;
    repeat (4) cycle();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pc !== want[i]) begin errors++; $display("FAIL jmp_seq got %0d want %0d", pc, want[i]); end
      cycle();
    end
    checks++;
    if (porta !== 4'b0001) begin errors++; $display("FAIL jmp_squash_porta got %b want 0001", porta); end
    while (pc != 7'd127) cycle();
    cycle();
    checks++;
    if (pc !== 7'd0) begin errors++; $display("FAIL pc_wrap got %0d want 0", pc); end
  endtask

  task automatic test_reset_mid();
    load_nops();
    mem[0] = w_twr(3, 9);
    mem[1] = w_twr(1, 4);
    mem[2] = w_twr(2, 8'h86);
    mem[3] = w_pwr(4'hA);
    do_reset();
    run_program("premid", 9);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (pc !== 7'd0) begin errors++; $display("FAIL mid_pc got %0d want 0", pc); end
    checks++;
    if (porta !== 4'b0001) begin errors++; $display("FAIL mid_porta got %b want 0001", porta); end
    checks++;
    if (dut.timer.cnt !== 8'd0) begin errors++; $display("FAIL mid_cnt got %0d want 0", dut.timer.cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.timer.tmr_reg[i] !== 8'd0) begin
        errors++; $display("FAIL mid_tmr%0d got %h want 00", i, dut.timer.tmr_reg[i]);
      end
    end
    model_reset();
    load_nops();
    @(negedge clk);
    rst = 1'b0;
    run_program("postmid", 6);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 128; i++) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: mem[i] = w_twr($urandom_range(0, 3), $urandom_range(0, 255));
          4, 5:       mem[i] = w_pwr($urandom_range(0, 15));
          6:          mem[i] = w_jmp($urandom_range(0, 127));
          default:    mem[i] = 16'($urandom);
        endcase
      end
      do_reset();
      run_program("random", 200);
    end
  endtask

  initial begin
    test_reset();
    test_nop_count();
    test_timer_pwm();
    test_shared_pin();
    test_disable();
    test_jmp();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
